// File: rtl/rr_arb_mux.sv
// N:1 arbiter (fixed-priority or round-robin) into a one-word output register; 1-cycle latency.
// A new word is accepted only when the register is empty or draining, so a stall shows as in_ready=0.
module rr_arb_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int SELW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  input  logic                 out_ready
);
  localparam logic [SELW:0]   NUM  = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N-1);

  logic [WIDTH-1:0] ch_data [N];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  gidx;
  logic [SELW:0]    scan;
  logic [N-1:0]     grant;
  logic             load;
  logic             found;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign load = ~out_valid | out_ready;

  // Scan starting at ptr; in fixed-priority mode ptr stays 0 so this is a plain lowest-index search.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (SELW+1)'(k);
      if (scan >= NUM) scan = scan - NUM;
      if (!found && in_valid[scan[SELW-1:0]]) begin
        found = 1'b1;
        gidx  = scan[SELW-1:0];
      end
    end
    if (found && load && !rst) grant[gidx] = 1'b1;
  end

  assign in_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gidx];
        out_sel   <= gidx;
        if (MODE == 1) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
        else           ptr <= '0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// Drives a round-robin and a fixed-priority instance with shared stimulus; a per-cycle model checks both.
module tb_rr_arb_mux;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SELW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic             out_ready;
  logic [N-1:0]     rdy1, rdy0;
  logic             ov1, ov0;
  logic [W-1:0]     od1, od0;
  logic [SELW-1:0]  os1, os0;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(W), .N(N), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(W), .N(N), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner per the arbitration rule; -1 when nobody requests.
  function automatic int pick(input int mode, input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == 1) ? (ptr + k) % N : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model state per instance: index 1 = round-robin, index 0 = fixed priority.
  bit m_v   [2];
  int m_d   [2];
  int m_s   [2];
  int m_ptr [2];

  always @(negedge clk) begin
    logic [N-1:0]    a_rdy;
    logic            a_v;
    logic [W-1:0]    a_d;
    logic [SELW-1:0] a_s;
    int              g;
    bit              ld;
    logic [N-1:0]    e_rdy;
    if (run) begin
      for (int m = 0; m < 2; m++) begin
        if (m == 1) begin a_rdy = rdy1; a_v = ov1; a_d = od1; a_s = os1; end
        else        begin a_rdy = rdy0; a_v = ov0; a_d = od0; a_s = os0; end
        if (rst) begin
          m_v[m] = 1'b0; m_d[m] = 0; m_s[m] = 0; m_ptr[m] = 0;
        end
        check($sformatf("u%0d.out_valid", m), 32'(a_v), 32'(m_v[m]));
        check($sformatf("u%0d.out_data", m), 32'(a_d), m_d[m]);
        check($sformatf("u%0d.out_sel", m), 32'(a_s), m_s[m]);
        ld = !m_v[m] || out_ready;
        g  = pick(m, m_ptr[m], in_valid);
        e_rdy = '0;
        if (!rst && ld && g >= 0) e_rdy[g] = 1'b1;
        check($sformatf("u%0d.in_ready", m), 32'(a_rdy), 32'(e_rdy));
        if (!rst && ld) begin
          if (g >= 0) begin
            m_v[m]   = 1'b1;
            m_d[m]   = int'(in_data[g*W +: W]);
            m_s[m]   = g;
            m_ptr[m] = (m == 1) ? (g + 1) % N : 0;
          end else begin
            m_v[m] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    run       = 1'b1;

    check("model_wrap", pick(1, 3, 4'b1001), 3);
    check("model_skip", pick(1, 1, 4'b1001), 3);
    check("model_fixed", pick(0, 3, 4'b1001), 0);
    check("model_idle", pick(1, 2, 4'b0000), -1);

    // Reset with every channel requesting
    @(negedge clk);
    check("rst_in_ready1", rdy1, 0);
    check("rst_in_ready0", rdy0, 0);
    check("rst_out_valid", ov1, 0);
    check("rst_out_data", od1, 0);
    check("rst_out_sel", os1, 0);

    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("first_in_ready", rdy1, 4'b0001);
    check("first_out_valid", ov1, 0);

    // All valid, out_ready high: round-robin rotation vs fixed priority
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr_valid", ov1, 1);
      check("rr_sel", os1, i % 4);
      check("rr_data", od1, 8'h11 * ((i % 4) + 1));
      check("rr_in_ready", rdy1, 4'b0001 << ((i + 1) % 4));
      check("fp_sel", os0, 0);
      check("fp_data", od0, 8'h11);
      check("fp_in_ready", rdy0, 4'b0001);
    end

    // Backpressure while holding 8'h22
    @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_data", od1, 8'h22);
      check("bp_sel", os1, 1);
      check("bp_valid", ov1, 1);
      check("bp_in_ready", rdy1, 0);
      check("bp_in_ready0", rdy0, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", rdy1, 4'b0100);
    check("bp_release_hold", od1, 8'h22);

    // Wrap-around: ptr=3 with channels 0 and 3 valid
    @(posedge clk); #1 in_valid = 4'b1001;
    @(negedge clk);
    check("bp_next_sel", os1, 2);
    check("bp_next_data", od1, 8'h33);
    check("wrap_ready_a", rdy1, 4'b1000);
    @(negedge clk);
    check("wrap_sel_a", os1, 3);
    check("wrap_ready_b", rdy1, 4'b0001);
    @(negedge clk);
    check("wrap_sel_b", os1, 0);
    check("wrap_ready_c", rdy1, 4'b1000);
    @(negedge clk);
    check("wrap_sel_c", os1, 3);
    check("wrap_fp_sel", os0, 0);

    // Sparse: single pulse on channel 2
    @(posedge clk); #1 in_valid = '0;
    @(posedge clk); #1 in_valid = 4'b0100; in_data[23:16] = 8'h5A;
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    check("sparse_valid", ov1, 1);
    check("sparse_data", od1, 8'h5A);
    check("sparse_sel", os1, 2);
    check("sparse_data0", od0, 8'h5A);
    @(negedge clk);
    check("sparse_idle_valid", ov1, 0);
    check("sparse_idle_data", od1, 8'h5A);
    check("sparse_idle_sel", os1, 2);

    // Asynchronous reset mid-operation while a word is held
    @(posedge clk); #1 in_valid = '1; out_ready = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_valid", ov1, 0);
    check("arst_data", od1, 0);
    check("arst_sel", os1, 0);
    check("arst_in_ready", rdy1, 0);
    check("arst_valid0", ov0, 0);
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

    // Randomized traffic, with occasional all-valid bursts and resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ((c % 500) < 60) ? 4'hF : 4'($urandom);
      in_data   = $urandom;
      out_ready = ((c % 500) < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    run = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
